// File: rtl/ticket_pulse_rx_pkg.sv
// -----------------------------------------------------------------------------
// ticket_pulse_rx_pkg
//
// Shared definitions for the ticket pulse receiver: FSM state encoding, the
// field widths of a report, the default inter-ticket gap, and two small helpers
// that decode a vector of simultaneous edge strobes.
// -----------------------------------------------------------------------------
package ticket_pulse_rx_pkg;

    // One pulse line per ticket type.
    localparam int NUM_LINES = 4;

    // Report field widths.
    localparam int TYPE_W  = 2;
    localparam int COUNT_W = 3;
    localparam int TOTAL_W = 8;

    // Gap timer width; wide enough for the largest legal GAP_CYCLES (255).
    localparam int TIMER_W = 8;

    // Idle clocks after the last locked-line edge that close a transaction.
    localparam int GAP_CYCLES_DEF = 16;

    // Count saturates here instead of wrapping.
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef logic [NUM_LINES-1:0] lines_t;
    typedef logic [TYPE_W-1:0]    type_t;
    typedef logic [COUNT_W-1:0]   count_t;
    typedef logic [TOTAL_W-1:0]   total_t;
    typedef logic [TIMER_W-1:0]   timer_t;

    // Receiver FSM: waiting for a first edge, accumulating edges on the locked
    // line, and holding a finished report until the consumer takes it.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Index of the lowest set bit; returns 0 for an all-zero vector (callers
    // only use the result when at least one bit is set).
    function automatic type_t lowest_line(input lines_t lines);
        type_t idx;
        idx = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (lines[i]) begin
                idx = type_t'(i);
            end
        end
        return idx;
    endfunction

    // True when more than one line strobes in the same cycle. Clearing the
    // lowest set bit leaves something behind only if a second bit was set.
    function automatic logic multi_hot(input lines_t lines);
        return (lines & (lines - lines_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/ticket_pulse_rx_if.sv
// -----------------------------------------------------------------------------
// ticket_pulse_rx_if
//
// Report handshake between the ticket receiver (master) and its consumer
// (slave). A report is offered with tkt_valid and taken on the first clock
// edge where tkt_valid and tkt_rdy are both high.
//
//   tkt_valid  master->slave  report available
//   tkt_rdy    slave->master  consumer accepts the report
//   tkt_type   master->slave  ticket type of the report, 0..3
//   tkt_count  master->slave  tickets counted in the report, 0..7
//   tkt_err    master->slave  an edge was seen on a line other than the
//                             locked one during this transaction
// -----------------------------------------------------------------------------
interface ticket_pulse_rx_if;
    import ticket_pulse_rx_pkg::*;

    logic   tkt_valid;
    logic   tkt_rdy;
    type_t  tkt_type;
    count_t tkt_count;
    logic   tkt_err;

    modport master (
        output tkt_valid,
        output tkt_type,
        output tkt_count,
        output tkt_err,
        input  tkt_rdy
    );

    modport slave (
        input  tkt_valid,
        input  tkt_type,
        input  tkt_count,
        input  tkt_err,
        output tkt_rdy
    );

endinterface

// File: rtl/pulse_sync_edge.sv
// -----------------------------------------------------------------------------
// pulse_sync_edge
//
// Brings one asynchronous pulse line into the clk domain and turns each rising
// edge into a single-cycle strobe. The strobe is registered, so it appears
// STAGES+1 clocks after the input rises.
//
// After reset the detector stays disarmed until the synchroniser has filled
// with real samples and the line has been seen low at least once, so a line
// that is already high when reset is released does not produce a strobe.
//
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   line    in   raw pulse line, asynchronous to clk
//   strobe  out  one-cycle pulse per detected rising edge
// -----------------------------------------------------------------------------
module pulse_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic strobe
);

    logic [STAGES-1:0] sync_q;      // synchroniser chain, [0] samples the pin
    logic [STAGES-1:0] fill_q;      // ones shift in as the chain fills after reset
    logic              seen_low_q;  // previous synchronised sample was a real 0
    logic              sync_out;
    logic              filled;
    logic              rise;

    assign sync_out = sync_q[STAGES-1];
    assign filled   = fill_q[STAGES-1];
    assign rise     = filled & sync_out & seen_low_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            fill_q     <= '0;
            seen_low_q <= 1'b0;
            strobe     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the previous
            // value of its neighbour; blocking here would collapse the chain
            // into a single stage.
            sync_q     <= {sync_q[STAGES-2:0], line};
            fill_q     <= {fill_q[STAGES-2:0], 1'b1};
            seen_low_q <= filled & ~sync_out;
            strobe     <= rise;
        end
    end

endmodule

// File: rtl/ticket_pulse_rx.sv
// -----------------------------------------------------------------------------
// ticket_pulse_rx
//
// Counts ticket pulses from a four-line dispenser and reports them in batches.
// The first edge locks the ticket type; further edges on that line extend the
// transaction and bump the count (saturating at 7). Once the locked line has
// been quiet for GAP_CYCLES clocks the batch is offered on the report
// handshake and, when accepted, added into that type's running total.
//
// Edges on other lines during a transaction only flag tkt_err. Edges that
// arrive while a report is waiting are dropped and raise the sticky tkt_ovr.
//
//   clk          in   system clock, rising-edge
//   rst_n        in   asynchronous active-low reset
//   co_in[3:0]   in   ticket pulse lines, bit n is ticket type n
//   tkt          --   report handshake (master side, see ticket_pulse_rx_if)
//   tkt_ovr      out  sticky: edges were dropped while a report was pending
//   busy         out  a transaction is counting or waiting to be reported
//   total0..3    out  cumulative accepted tickets per type, modulo 256
// -----------------------------------------------------------------------------
module ticket_pulse_rx
    import ticket_pulse_rx_pkg::*;
#(
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,   // legal range 2..255
    parameter int SYNC_STAGES = 2                 // legal range 2..3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_LINES-1:0]     co_in,
    ticket_pulse_rx_if.master        tkt,
    output logic                     tkt_ovr,
    output logic                     busy,
    output logic [TOTAL_W-1:0]       total0,
    output logic [TOTAL_W-1:0]       total1,
    output logic [TOTAL_W-1:0]       total2,
    output logic [TOTAL_W-1:0]       total3
);

    localparam timer_t GAP_LOAD = timer_t'(GAP_CYCLES);

    // -------------------------------------------------------------------------
    // Per-line synchroniser and rising-edge detector
    // -------------------------------------------------------------------------
    lines_t strobe;

    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
        pulse_sync_edge #(
            .STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk    (clk),
            .rst_n  (rst_n),
            .line   (co_in[gi]),
            .strobe (strobe[gi])
        );
    end

    // -------------------------------------------------------------------------
    // Transaction state
    // -------------------------------------------------------------------------
    state_e state_q, state_d;
    type_t  type_q,  type_d;
    count_t count_q, count_d;
    timer_t timer_q, timer_d;
    logic   err_q,   err_d;
    logic   ovr_q,   ovr_d;
    total_t total_q [NUM_LINES];

    lines_t locked_mask;
    logic   locked_hit;
    logic   other_hit;
    logic   accept;

    assign locked_mask = lines_t'(1) << type_q;
    assign locked_hit  = (strobe & locked_mask) != '0;
    assign other_hit   = (strobe & ~locked_mask) != '0;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable is given its hold value before the case so that
        // paths which do not mention it keep the register, not a latch.
        state_d = state_q;
        type_d  = type_q;
        count_d = count_q;
        timer_d = timer_q;
        err_d   = err_q;
        ovr_d   = ovr_q;
        accept  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (strobe != '0) begin
                    // Simultaneous first edges: lowest line wins, the rest
                    // are reported as an error on this transaction.
                    type_d  = lowest_line(strobe);
                    count_d = count_t'(1);
                    timer_d = GAP_LOAD;
                    err_d   = multi_hot(strobe);
                    state_d = ST_COUNT;
                end
            end

            ST_COUNT: begin
                if (other_hit) begin
                    err_d = 1'b1;
                end
                if (locked_hit) begin
                    // A locked-line edge takes priority over the timer running
                    // out in the same cycle, so no ticket is ever left behind.
                    count_d = (count_q == COUNT_MAX) ? count_q
                                                     : count_q + count_t'(1);
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - timer_t'(1);
                    // Leave on the step that brings the timer to zero; this
                    // makes the first-edge-to-valid latency GAP_CYCLES+1.
                    if (timer_q <= timer_t'(1)) begin
                        state_d = ST_REPORT;
                    end
                end
            end

            ST_REPORT: begin
                // The report registers are frozen; any edge now is lost,
                // including one on the accepting edge itself.
                if (strobe != '0) begin
                    ovr_d = 1'b1;
                end
                if (tkt.tkt_rdy) begin
                    accept  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            type_q  <= '0;
            count_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            count_q <= count_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    // Running totals, one accumulator per ticket type.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the totals are plain flops, not a RAM, so they can and must
            // clear with everything else; a reset mid-transaction therefore
            // leaves no partial batch behind.
            for (int i = 0; i < NUM_LINES; i++) begin
                total_q[i] <= '0;
            end
        end else if (accept) begin
            total_q[type_q] <= total_q[type_q] + total_t'(count_q);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tkt.tkt_valid = (state_q == ST_REPORT);
    assign tkt.tkt_type  = type_q;
    assign tkt.tkt_count = count_q;
    assign tkt.tkt_err   = err_q;

    assign tkt_ovr = ovr_q;
    assign busy    = (state_q != ST_IDLE);

    assign total0 = total_q[0];
    assign total1 = total_q[1];
    assign total2 = total_q[2];
    assign total3 = total_q[3];

endmodule

// File: tb/tb_ticket_pulse_rx.sv
// -----------------------------------------------------------------------------
// tb_ticket_pulse_rx
//
// Directed bench for ticket_pulse_rx with GAP_CYCLES=16, SYNC_STAGES=2.
// Inputs are driven and outputs sampled on the falling clock edge. Timing
// references count falling edges from the one where a line is first raised
// (edge 0): the strobe is internal after 3 edges, COUNT is visible at edge 4
// and, with no further edges, tkt_valid is visible at edge 20.
// -----------------------------------------------------------------------------
module tb_ticket_pulse_rx;
    import ticket_pulse_rx_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] co_in = '0;
    logic       tkt_ovr;
    logic       busy;
    logic [7:0] total0, total1, total2, total3;
    logic [7:0] tot [4];

    ticket_pulse_rx_if tkt ();

    ticket_pulse_rx #(
        .GAP_CYCLES  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .co_in   (co_in),
        .tkt     (tkt),
        .tkt_ovr (tkt_ovr),
        .busy    (busy),
        .total0  (total0),
        .total1  (total1),
        .total2  (total2),
        .total3  (total3)
    );

    assign tot[0] = total0;
    assign tot[1] = total1;
    assign tot[2] = total2;
    assign tot[3] = total3;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] exp_total [4];

    typedef struct {
        logic [3:0] mask;       // lines pulsed together
        int         npulses;
        int         spacing;    // cycles between rising edges
        logic [1:0] exp_type;
        logic [2:0] exp_count;
        logic       exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_valid"}, 32'(tkt.tkt_valid), 32'd0);
        check({pfx, "_busy"},  32'(busy),          32'd0);
        check({pfx, "_type"},  32'(tkt.tkt_type),  32'd0);
        check({pfx, "_count"}, 32'(tkt.tkt_count), 32'd0);
        check({pfx, "_err"},   32'(tkt.tkt_err),   32'd0);
        check({pfx, "_ovr"},   32'(tkt_ovr),       32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_total%0d", pfx, i), 32'(tot[i]), 32'd0);
        end
    endtask

    task automatic check_totals(input string pfx);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_total%0d", pfx, i), 32'(tot[i]), 32'(exp_total[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        vecs[0] = '{4'b0010, 3, 10, 2'd1, 3'd3, 1'b0};
        vecs[1] = '{4'b0001, 9, 10, 2'd0, 3'd7, 1'b0};
        vecs[2] = '{4'b0100, 1,  4, 2'd2, 3'd1, 1'b0};
        vecs[3] = '{4'b1000, 4,  6, 2'd3, 3'd4, 1'b0};
        vecs[4] = '{4'b0010, 7,  4, 2'd1, 3'd7, 1'b0};
        vecs[5] = '{4'b1010, 1,  4, 2'd1, 3'd1, 1'b1};
        vecs[6] = '{4'b1100, 2,  8, 2'd2, 3'd2, 1'b1};
        for (int i = 0; i < 4; i++) exp_total[i] = '0;

        // ---------------- reset state ----------------
        tkt.tkt_rdy = 1'b1;
        #12;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();

        // ---------------- reset mid-COUNT, then a line held high through reset
        cyc = 0;
        co_in[0] = 1'b1; repeat (2) tick(); co_in[0] = 1'b0;
        repeat (4) tick();
        co_in[0] = 1'b1; repeat (2) tick(); co_in[0] = 1'b0;
        while (cyc < 14) tick();
        check("midcount_busy",  32'(busy),          32'd1);
        check("midcount_count", 32'(tkt.tkt_count), 32'd2);
        rst_n = 1'b0;
        #1;
        check_all_zero("midcount_rst");
        co_in[2] = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (busy || tkt.tkt_valid) seen++;
        end
        check("held_high_no_strobe", 32'(seen), 32'd0);
        co_in[2] = 1'b0;
        repeat (6) tick();
        check("held_high_release_busy", 32'(busy), 32'd0);
        check_totals("after_rst_abort");

        // ---------------- table-driven transactions (rdy=1) ----------------
        for (int v = 0; v < 7; v++) begin
            tick();
            cyc = 0;
            for (int p = 0; p < vecs[v].npulses; p++) begin
                co_in = vecs[v].mask;
                repeat (2) tick();
                co_in = '0;
                repeat (vecs[v].spacing - 2) tick();
            end
            while (!tkt.tkt_valid && cyc < 400) tick();
            check($sformatf("v%0d_valid", v), 32'(tkt.tkt_valid), 32'd1);
            check($sformatf("v%0d_type", v),  32'(tkt.tkt_type),  32'(vecs[v].exp_type));
            check($sformatf("v%0d_count", v), 32'(tkt.tkt_count), 32'(vecs[v].exp_count));
            check($sformatf("v%0d_err", v),   32'(tkt.tkt_err),   32'(vecs[v].exp_err));
            exp_total[vecs[v].exp_type] = exp_total[vecs[v].exp_type] + 8'(vecs[v].exp_count);
            tick();
            check($sformatf("v%0d_valid_drop", v), 32'(tkt.tkt_valid), 32'd0);
            check_totals($sformatf("v%0d", v));
            repeat (3) tick();
        end

        // ---------------- foreign line mid-transaction ----------------
        tick();
        cyc = 0;
        co_in[2] = 1'b1; repeat (2) tick(); co_in[2] = 1'b0;
        repeat (3) tick();
        co_in[3] = 1'b1; repeat (2) tick(); co_in[3] = 1'b0;
        while (!tkt.tkt_valid && cyc < 60) tick();
        check("foreign_latency", 32'(cyc),           32'd20);
        check("foreign_type",    32'(tkt.tkt_type),  32'd2);
        check("foreign_count",   32'(tkt.tkt_count), 32'd1);
        check("foreign_err",     32'(tkt.tkt_err),   32'd1);
        exp_total[2] = exp_total[2] + 8'd1;
        tick();
        check_totals("foreign");
        repeat (3) tick();

        // ---------------- locked edge on the timer-expiry cycle ----------------
        cyc = 0;
        co_in[1] = 1'b1; repeat (2) tick(); co_in[1] = 1'b0;
        while (cyc < 16) tick();
        co_in[1] = 1'b1; repeat (2) tick(); co_in[1] = 1'b0;
        while (cyc < 20) tick();
        check("race_no_report", 32'(tkt.tkt_valid), 32'd0);
        check("race_busy",      32'(busy),          32'd1);
        while (!tkt.tkt_valid && cyc < 80) tick();
        check("race_latency", 32'(cyc),           32'd36);
        check("race_type",    32'(tkt.tkt_type),  32'd1);
        check("race_count",   32'(tkt.tkt_count), 32'd2);
        exp_total[1] = exp_total[1] + 8'd2;
        tick();
        check_totals("race");
        repeat (3) tick();

        // ---------------- report held with rdy=0, overrun ----------------
        tkt.tkt_rdy = 1'b0;
        tick();
        cyc = 0;
        co_in[3] = 1'b1; repeat (2) tick(); co_in[3] = 1'b0;
        repeat (4) tick();
        co_in[3] = 1'b1; repeat (2) tick(); co_in[3] = 1'b0;
        while (!tkt.tkt_valid && cyc < 100) tick();
        check("hold_latency", 32'(cyc),           32'd26);
        check("hold_type",    32'(tkt.tkt_type),  32'd3);
        check("hold_count",   32'(tkt.tkt_count), 32'd2);
        check("hold_ovr_pre", 32'(tkt_ovr),       32'd0);
        co_in[3] = 1'b1; repeat (2) tick(); co_in[3] = 1'b0;
        repeat (6) tick();
        check("hold_valid",  32'(tkt.tkt_valid), 32'd1);
        check("hold_type2",  32'(tkt.tkt_type),  32'd3);
        check("hold_count2", 32'(tkt.tkt_count), 32'd2);
        check("hold_err",    32'(tkt.tkt_err),   32'd0);
        check("hold_ovr",    32'(tkt_ovr),       32'd1);
        check("hold_total3", 32'(total3),        32'(exp_total[3]));
        tkt.tkt_rdy = 1'b1;
        tick();
        exp_total[3] = exp_total[3] + 8'd2;
        check("hold_valid_drop", 32'(tkt.tkt_valid), 32'd0);
        check("hold_total3_acc", 32'(total3),        32'(exp_total[3]));
        repeat (30) tick();
        check("ovr_sticky", 32'(tkt_ovr), 32'd1);
        check("ovr_no_new_report", 32'(busy), 32'd0);

        // ---------------- reset mid-COUNT clears everything ----------------
        cyc = 0;
        co_in[2] = 1'b1; repeat (2) tick(); co_in[2] = 1'b0;
        repeat (6) tick();
        check("final_busy", 32'(busy),         32'd1);
        check("final_type", 32'(tkt.tkt_type), 32'd2);
        rst_n = 1'b0;
        #1;
        check_all_zero("final_rst");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
